// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Write-back arbiter in front of the register file write port.
//               Merges the in-order MEM/WB result (priority) with results
//               from a long-latency unit buffered in a small FIFO. Handles
//               WAW squashing, starvation stalls and a pending-rd mask.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_stall,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic [4:0]       ent_rd_q   [DEPTH];
  logic [4:0]       ent_rd_d   [DEPTH];
  logic [XLEN-1:0]  ent_data_q [DEPTH];
  logic [XLEN-1:0]  ent_data_d [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             lu_ready_q, lu_ready_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

  logic             empty, pipe_eff, lu_push, pop;
  logic [AW-1:0]    head, tail;

  // Arbitration decisions for this cycle, from registered state and inputs.
  always_comb begin
    empty      = (wptr_q == rptr_q);
    pipe_stall = (starve_q == STARVE_MAX) && !empty;
    pipe_eff   = pipe_we && (pipe_rd != 5'd0) && !pipe_stall;
    // Pushes to x0 are handshaken but never occupy a slot.
    lu_push    = lu_valid && lu_ready_q && (lu_rd != 5'd0);
    pop        = !pipe_eff && !empty;
    head       = rptr_q[AW-1:0];
    tail       = wptr_q[AW-1:0];
  end

  // Next-state for FIFO, starvation counter and the registered write port.
  always_comb begin
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    ent_vld_d  = ent_vld_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    // A pipe result is younger than anything queued: kill older writes to rd.
    if (pipe_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_rd_q[i] == pipe_rd) begin
          ent_vld_d[i] = 1'b0;
        end
      end
    end

    if (pipe_eff) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (pop) begin
      ent_vld_d[head] = 1'b0;
      rptr_d          = rptr_q + PTR_ONE;
      if (ent_vld_q[head]) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ent_rd_q[head];
        rf_wdata_d = ent_data_q[head];
      end
    end

    // Head and tail slots differ whenever a push and a pop coincide, so the
    // push may write its slot unconditionally.
    if (lu_push) begin
      ent_rd_d[tail]   = lu_rd;
      ent_data_d[tail] = lu_data;
      ent_vld_d[tail]  = !(pipe_eff && (lu_rd == pipe_rd));
      wptr_d           = wptr_q + PTR_ONE;
    end

    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_ONE;
    end

    lu_ready_d = !((wptr_d[AW] != rptr_d[AW]) &&
                   (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
      ent_vld_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      starve_q   <= '0;
      lu_ready_q <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      ent_vld_q  <= ent_vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      starve_q   <= starve_d;
      lu_ready_q <= lu_ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Destinations still owed a write by the long-latency path.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i]) begin
        pending_mask[ent_rd_q[i]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  assign lu_ready = lu_ready_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter directly upstream of the 64-bit register file; drives its single write port (we / write_addr / write_data).
- Merges two result sources:
  - the in-order MEM/WB pipeline result, which has priority and no backpressure;
  - a long-latency unit (multi-cycle mul/div/load-miss), buffered in a small FIFO with valid/ready.
- Handles WAW squashing, starvation-driven pipeline stalls and a pending-destination mask for the hazard unit.

Parameters:
XLEN, 64, data width of results and register file.
DEPTH, 4, long-latency FIFO entries; power of two, ≥2.
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be blocked before pipe_stall asserts; ≥1.

Ports:
clk  in  1  clock; all state updates on posedge (register file writes on negedge, so outputs are stable half a cycle before).
rst  in  1  asynchronous, active-high reset.
pipe_we  in  1  MEM/WB write enable.
pipe_rd  in  5  MEM/WB destination register.
pipe_data  in  XLEN  MEM/WB result.
pipe_stall  out  1  hold MEM/WB this cycle; pipe_* is ignored and must be re-presented.
lu_valid  in  1  long-latency result valid.
lu_rd  in  5  long-latency destination.
lu_data  in  XLEN  long-latency result.
lu_ready  out  1  FIFO can accept; registered, equals !full.
rf_we  out  1  register file write enable.
rf_waddr  out  5  register file write address.
rf_wdata  out  XLEN  register file write data.
pending_mask  out  32  bit i set iff a valid FIFO entry targets xi; bit 0 is always 0.

Behaviour:
- Reset (async):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, all entry valid bits 0.
  - lu_ready=1, starve counter=0, pipe_stall=0, pending_mask=0.
- Pipe write is "effective" when pipe_we=1, pipe_rd≠0 and pipe_stall=0.
- Accept: LU push when lu_valid && lu_ready. Push with lu_rd=0 is accepted and discarded; no entry is created.
- Per-cycle arbitration, registered (1-cycle latency to rf_*):
  1. Effective pipe write → rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_data; FIFO does not pop.
  2. Else, FIFO non-empty → pop head.
     - Head valid → rf_we=1 with head rd/data.
     - Head squashed → rf_we=0 (drain cycle).
  3. Else → rf_we=0; rf_waddr/rf_wdata hold their previous values.
- WAW squash, on each effective pipe write to rd:
  - Clear the valid bit of every FIFO entry with the same rd.
  - An LU push in the same cycle to the same rd is stored with valid=0.
  - Long-latency results are by definition older than concurrent pipe results.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and does not pop; clears on any pop or when empty; saturates at STARVE_LIMIT.
  - pipe_stall = (counter==STARVE_LIMIT) && !empty, combinational from registered state.
  - While pipe_stall=1, pipe inputs are ignored, so the FIFO pops that cycle.
- Full/empty:
  - Pointers are log2(DEPTH)+1 bits; wrap-around is by MSB compare.
  - A push and a pop in the same cycle are both legal; lu_ready reflects full at the start of the cycle, so there is no push-when-full.
  - lu_valid while lu_ready=0: no state change; the source holds.
- pending_mask: OR over valid entries of onehot(rd); it reflects post-edge state.
- Reset mid-operation: all FIFO contents are lost; rf_we drops immediately (async). Upstream is reset concurrently.
- x0: never written; rf_we never asserts with rf_waddr=0.

Test Plan:
- Pipe only: pipe_we=1, rd=5, data=0x1234 for one cycle → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; the following cycle rf_we=0.
- LU drain: push rd=3 then rd=7 (data 0xA, 0xB), no pipe traffic → rf writes x3=0xA then x7=0xB on consecutive cycles; pending_mask goes 0x88 → 0x80 → 0.
- Full: push 5 entries back-to-back while pipe_we=1 every cycle → lu_ready=0 after 4 pushes; 5th entry held then accepted after a pop; no entry lost; order preserved.
- WAW squash: FIFO holds rd=9 (0x1); pipe writes rd=9 (0x2) → rf x9=0x2; later pop of the rd=9 entry gives rf_we=0; pending bit 9 clears on the pipe write.
- Starvation: FIFO holds 1 entry, pipe_we=1 (rd=4) continuously → pipe_stall=1 on cycle STARVE_LIMIT(8) after the push; that cycle's pipe write is dropped and the FIFO entry is written; pipe_stall=0 next cycle.
- Reset mid-drain: 3 entries queued, assert rst → rf_we=0 same cycle, pending_mask=0, lu_ready=1; after release, no stale writes occur.
